// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the controller state encoding, the default datapath width and the load-use compare.
package hazard_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_W        = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  function automatic logic load_use(
    input logic             memread,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic             use_rs1,
    input logic             use_rs2
  );
    return memread && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count visible the cycle after inc; no backpressure, async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects and data-memory holds.
// Latency: redirect/stall outputs are combinational (0 cycles); a memory stall holds the whole pipe.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branchtaken,
  input  logic [XLEN-1:0]  BranchALUXpipe_out,
  input  logic             dmem_busy,
  output logic             FD_pipeready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  state_t            state;
  logic              pend;
  logic [XLEN-1:0]   tgt_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              err_q;
  logic              lu;
  logic              stall_inc;
  logic              flush_inc;

  assign lu          = load_use(ex_memread, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
  assign wait_nxt    = wait_cnt + WAIT_W'(1);
  assign err_timeout = err_q;

  always_comb begin
    FD_pipeready = 1'b1;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    pc_target    = '0;
    fd_flush     = 1'b0;
    dx_bubble    = 1'b0;
    pipe_hold    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmem_busy) begin
          FD_pipeready = 1'b0;
          pc_write     = 1'b0;
          pipe_hold    = 1'b1;
          stall_inc    = 1'b1;
        end else if (branchtaken) begin
          pc_sel    = 1'b1;
          pc_target = BranchALUXpipe_out;
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          FD_pipeready = 1'b0;
          pc_write     = 1'b0;
          dx_bubble    = 1'b1;
          stall_inc    = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // A branch seen while already waiting is a stale EX result and is ignored.
        if (dmem_busy) begin
          FD_pipeready = 1'b0;
          pc_write     = 1'b0;
          pipe_hold    = 1'b1;
          stall_inc    = 1'b1;
        end else if (pend) begin
          pc_sel    = 1'b1;
          pc_target = tgt_q;
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          FD_pipeready = 1'b0;
          pc_write     = 1'b0;
          dx_bubble    = 1'b1;
          stall_inc    = 1'b1;
        end
      end
      ST_FAULT: begin
        FD_pipeready = 1'b0;
        pc_write     = 1'b0;
        pipe_hold    = 1'b1;
        dx_bubble    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= ST_RUN;
      pend     <= 1'b0;
      tgt_q    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dmem_busy) begin
            wait_cnt <= '0;
            state    <= ST_MEM_WAIT;
            if (branchtaken) begin
              tgt_q <= BranchALUXpipe_out;
              pend  <= 1'b1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_busy) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == TIMEOUT_V) begin
              err_q <= 1'b1;
              state <= ST_FAULT;
            end
          end else begin
            pend  <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_FAULT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_n (reset_i),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_n (reset_i),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread, branchtaken, dmem_busy;
  logic [XLEN-1:0]  BranchALUXpipe_out;
  logic             FD_pipeready, pc_write, pc_sel, fd_flush, dx_bubble, pipe_hold, err_timeout;
  logic [XLEN-1:0]  pc_target;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tracks how long the memory has been busy rather than a state machine.
  logic            m_prev_busy;
  int              m_busy_len;
  logic            m_fault;
  logic            m_err;
  logic [XLEN-1:0] m_pend_q[$];
  int              m_stalls;
  int              m_flushes;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_use_rs1         (id_use_rs1),
    .id_use_rs2         (id_use_rs2),
    .ex_rd              (ex_rd),
    .ex_memread         (ex_memread),
    .branchtaken        (branchtaken),
    .BranchALUXpipe_out (BranchALUXpipe_out),
    .dmem_busy          (dmem_busy),
    .FD_pipeready       (FD_pipeready),
    .pc_write           (pc_write),
    .pc_sel             (pc_sel),
    .pc_target          (pc_target),
    .fd_flush           (fd_flush),
    .dx_bubble          (dx_bubble),
    .pipe_hold          (pipe_hold),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt),
    .err_timeout        (err_timeout)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : x;
  endfunction

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    branchtaken = 1'b0; dmem_busy = 1'b0; BranchALUXpipe_out = '0;
  endtask

  task automatic model_reset();
    m_prev_busy = 1'b0; m_busy_len = 0; m_fault = 1'b0; m_err = 1'b0;
    m_pend_q.delete(); m_stalls = 0; m_flushes = 0;
  endtask

  // Pulse reset between clock edges and check the asynchronous effect; called right after a negedge.
  task automatic async_reset();
    idle_inputs();
    #2 reset_i = 1'b0;
    #1;
    model_reset();
    check("rst_fd_ready", 64'(FD_pipeready), 64'd1);
    check("rst_pc_write", 64'(pc_write), 64'd1);
    check("rst_pc_sel", 64'(pc_sel), 64'd0);
    check("rst_pc_target", pc_target, 64'd0);
    check("rst_bubble", 64'(dx_bubble), 64'd0);
    check("rst_hold", 64'(pipe_hold), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    #1 reset_i = 1'b1;
    @(negedge clk_i);
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic cycle();
    logic e_fdr, e_pcw, e_sel, e_ff, e_db, e_hold, do_stall, do_flush, lu;
    logic [XLEN-1:0] e_tgt;
    e_fdr = 1; e_pcw = 1; e_sel = 0; e_tgt = '0; e_ff = 0; e_db = 0; e_hold = 0;
    do_stall = 0; do_flush = 0;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_fault) begin
      e_fdr = 0; e_pcw = 0; e_hold = 1; e_db = 1;
    end else if (dmem_busy) begin
      e_fdr = 0; e_pcw = 0; e_hold = 1; do_stall = 1;
    end else if (m_prev_busy && m_pend_q.size() > 0) begin
      e_sel = 1; e_tgt = m_pend_q[0]; e_ff = 1; e_db = 1; do_flush = 1;
    end else if (!m_prev_busy && branchtaken) begin
      e_sel = 1; e_tgt = BranchALUXpipe_out; e_ff = 1; e_db = 1; do_flush = 1;
    end else if (lu) begin
      e_fdr = 0; e_pcw = 0; e_db = 1; do_stall = 1;
    end
    #1;
    check("fd_pipeready", 64'(FD_pipeready), 64'(e_fdr));
    check("pc_write", 64'(pc_write), 64'(e_pcw));
    check("pc_sel", 64'(pc_sel), 64'(e_sel));
    check("pc_target", pc_target, e_tgt);
    check("fd_flush", 64'(fd_flush), 64'(e_ff));
    check("dx_bubble", 64'(dx_bubble), 64'(e_db));
    check("pipe_hold", 64'(pipe_hold), 64'(e_hold));
    check("stall_cnt", 64'(stall_cnt), 64'(sat(m_stalls)));
    check("flush_cnt", 64'(flush_cnt), 64'(sat(m_flushes)));
    check("err_timeout", 64'(err_timeout), 64'(m_err));
    @(posedge clk_i);
    if (!m_fault) begin
      if (dmem_busy) begin
        if (!m_prev_busy && branchtaken) m_pend_q.push_back(BranchALUXpipe_out);
        m_busy_len++;
        if (m_busy_len == TIMEOUT + 1) begin
          m_fault = 1'b1;
          m_err   = 1'b1;
        end
        m_prev_busy = 1'b1;
      end else begin
        if (m_prev_busy && m_pend_q.size() > 0) void'(m_pend_q.pop_front());
        m_prev_busy = 1'b0;
        m_busy_len  = 0;
      end
      m_stalls  += int'(do_stall);
      m_flushes += int'(do_flush);
    end
    @(negedge clk_i);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset_i = 1'b0;
    #1;
    check("por_stall_cnt", 64'(stall_cnt), 64'd0);
    check("por_err", 64'(err_timeout), 64'd0);
    check("por_fd_ready", 64'(FD_pipeready), 64'd1);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Load-use: one bubble, then the EX slot is a bubble and the hazard is gone.
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 check("lu_bubble", 64'(dx_bubble), 64'd1);
    cycle();
    ex_memread = 0;
    cycle();
    check("lu_stall_once", 64'(stall_cnt), 64'd1);
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    #1 check("lu_x0_no_bubble", 64'(dx_bubble), 64'd0);
    cycle();
    check("lu_x0_stall_cnt", 64'(stall_cnt), 64'd1);

    // Branch in RUN redirects in the same cycle.
    async_reset();
    branchtaken = 1; BranchALUXpipe_out = 64'h40;
    #1 check("br_target", pc_target, 64'h40);
    cycle();
    branchtaken = 0;
    cycle();
    check("br_flush_cnt", 64'(flush_cnt), 64'd1);

    // Branch during a 3-cycle memory stall is redirected when busy drops.
    async_reset();
    dmem_busy = 1; branchtaken = 1; BranchALUXpipe_out = 64'h80;
    cycle();
    branchtaken = 0; BranchALUXpipe_out = 64'h1234;
    cycle();
    cycle();
    dmem_busy = 0;
    #1 check("mw_redirect_target", pc_target, 64'h80);
    cycle();
    check("mw_stall_cnt", 64'(stall_cnt), 64'd3);
    check("mw_flush_cnt", 64'(flush_cnt), 64'd1);

    // Timeout: RUN cycle plus TIMEOUT waiting cycles enters FAULT.
    async_reset();
    dmem_busy = 1;
    repeat (TIMEOUT + 1) cycle();
    check("to_err", 64'(err_timeout), 64'd1);
    dmem_busy = 0; branchtaken = 1; BranchALUXpipe_out = 64'h99;
    #1 check("to_fault_hold", 64'(pipe_hold), 64'd1);
    repeat (3) cycle();
    check("to_err_sticky", 64'(err_timeout), 64'd1);
    async_reset();

    // Saturation of the stall counter.
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    repeat (20) cycle();
    check("sat_stall_cnt", 64'(stall_cnt), 64'd15);

    // Reset mid-wait drops the pending redirect.
    async_reset();
    dmem_busy = 1; branchtaken = 1; BranchALUXpipe_out = 64'hABC0;
    cycle();
    branchtaken = 0;
    cycle();
    async_reset();
    #1 check("rst_pend_lost", 64'(pc_sel), 64'd0);
    cycle();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        async_reset();
      end
      id_rs1             = 5'($urandom_range(0, 3));
      id_rs2             = 5'($urandom_range(0, 3));
      ex_rd              = 5'($urandom_range(0, 3));
      id_use_rs1         = 1'($urandom_range(0, 1));
      id_use_rs2         = 1'($urandom_range(0, 1));
      ex_memread         = 1'($urandom_range(0, 1));
      branchtaken        = ($urandom_range(0, 3) == 0);
      dmem_busy          = ($urandom_range(0, 2) == 0);
      BranchALUXpipe_out = {$urandom, $urandom};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
